// File: rtl/if_id_ctrl.sv
// Pipeline sequencer driving PC / IF/ID / ID/EX enables for stalls, flushes, memory wait and halt.
// Optional IF_ID_CTRL_PERF_EN adds saturating stall/flush/wait event counters.
module if_id_ctrl #(
    parameter int ADDR_W              = 14,
    parameter int REG_W               = 5,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int LU_STALL_CYCLES     = 1,
    parameter int MEM_TIMEOUT         = 255
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              imem_ready,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic              mem_err,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
    output logic [31:0]       wait_count,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_LU_STALL = 3'd1,
        S_FLUSH    = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    localparam logic [3:0] BF_CNT   = 4'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [3:0] LU_CNT   = 4'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] MT_CNT   = 8'(MEM_TIMEOUT);
    localparam logic       BF_MULTI = (BRANCH_FLUSH_CYCLES > 1);
    localparam logic       LU_MULTI = (LU_STALL_CYCLES > 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       mem_err_q, mem_err_d;
    logic       hz;
    logic       run_decode;

    assign hz = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wcnt_d         = wcnt_q;
        mem_err_d      = mem_err_q;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        redirect_valid = 1'b0;
        run_decode     = 1'b0;

        case (state_q)
            S_RUN: run_decode = 1'b1;
            S_LU_STALL: begin
                if (branch_taken) begin
                    run_decode = 1'b1;
                end else begin
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (branch_taken) begin
                    run_decode = 1'b1;
                end else begin
                    pc_en        = imem_ready;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (imem_ready) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_d = S_RUN;
                    end
                end
            end
            S_MEM_WAIT: begin
                // Ready ends the wait and that same cycle is decoded exactly like RUN.
                if (branch_taken || imem_ready) begin
                    run_decode = 1'b1;
                end else begin
                    id_ex_bubble = 1'b1;
                    if (wcnt_q == MT_CNT) begin
                        mem_err_d = 1'b1;
                        wcnt_d    = '0;
                        state_d   = S_HALTED;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            S_HALTED: begin
                id_ex_bubble = 1'b1;
                if (resume && !mem_err_q && !halt_req) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        if (run_decode) begin
            state_d = S_RUN;
            cnt_d   = '0;
            wcnt_d  = '0;
            if (branch_taken) begin
                redirect_valid = 1'b1;
                pc_en          = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_bubble   = 1'b1;
                if (BF_MULTI) begin
                    state_d = S_FLUSH;
                    cnt_d   = BF_CNT;
                end
            end else if (halt_req) begin
                id_ex_bubble = 1'b1;
                state_d      = S_HALTED;
            end else if (!imem_ready) begin
                id_ex_bubble = 1'b1;
                wcnt_d       = 8'd1;
                state_d      = S_MEM_WAIT;
            end else if (hz) begin
                id_ex_bubble = 1'b1;
                if (LU_MULTI) begin
                    state_d = S_LU_STALL;
                    cnt_d   = LU_CNT;
                end
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end

        if (!nreset) begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_valid = 1'b0;
        end
    end

    assign redirect_addr = redirect_valid ? branch_target : '0;
    assign halted        = (state_q == S_HALTED);
    assign mem_err       = mem_err_q;
    assign dbg_state_o   = state_q;

`ifdef IF_ID_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (!if_id_en && !if_id_flush && (state_q != S_HALTED) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if ((state_q == S_MEM_WAIT) && (wait_cnt_q != '1))
                wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
    assign wait_count  = wait_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
    assign wait_count  = '0;
`endif

endmodule
